mem_responder: RTL and testbench

- Memory-side responder for the control unit's rd/we memory interface. Serves 8-bit reads and writes to a 16-word register-file store, addressed by the 4-bit operand field.
- Adds a valid/ready request handshake, a configurable read latency and a held response, so the control unit can stall on memory.
- Sits between the control unit (initiator) and the LEDR debug output.

---
 rtl/proc_pkg.sv | 13 +
 rtl/mem_array.sv | 40 ++++
 rtl/mem_responder.sv | 129 ++++++++++++
 tb/tb_mem_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor-side types and default widths for the control unit, ALU and memory responder.
package proc_pkg;

    localparam int PROC_DATA_W = 8;
    localparam int PROC_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Register-file store: synchronous clear on reset, one write port, one registered read port.
module mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            // Only updated on a read capture so the response holds between transactions.
            if (re_i) begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: valid/ready request, programmable read latency, held response.
// Optional write acknowledge enabled by defining MEM_RESPONDER_WRITE_ACK_EN.
module mem_responder
    import proc_pkg::*;
#(
    parameter int DATA_W   = PROC_DATA_W,
    parameter int ADDR_W   = PROC_ADDR_W,
    parameter int READ_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
`ifdef MEM_RESPONDER_WRITE_ACK_EN
    logic              ack_sel_q, ack_sel_d;
    logic [DATA_W-1:0] wack_q, wack_d;
`endif

    mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clock   (clock),
        .reset   (reset),
        .we_i    (mem_we),
        .waddr_i (req_addr),
        .wdata_i (req_wdata),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
`ifdef MEM_RESPONDER_WRITE_ACK_EN
            ack_sel_q <= 1'b0;
            wack_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
`ifdef MEM_RESPONDER_WRITE_ACK_EN
            ack_sel_q <= ack_sel_d;
            wack_q    <= wack_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_raddr = addr_q;
`ifdef MEM_RESPONDER_WRITE_ACK_EN
        ack_sel_d = ack_sel_q;
        wack_d    = wack_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    if (req_we) begin
                        mem_we = 1'b1;
`ifdef MEM_RESPONDER_WRITE_ACK_EN
                        ack_sel_d = 1'b1;
                        wack_d    = req_wdata;
                        state_d   = RESP;
`endif
                    end else begin
`ifdef MEM_RESPONDER_WRITE_ACK_EN
                        ack_sel_d = 1'b0;
`endif
                        cnt_d = 4'(READ_LAT - 1);
                        if (READ_LAT == 1) begin
                            mem_re    = 1'b1;
                            mem_raddr = req_addr;
                            state_d   = RESP;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    mem_re  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
`ifdef MEM_RESPONDER_WRITE_ACK_EN
        rsp_rdata = ack_sel_q ? wack_q : mem_rdata;
`else
        rsp_rdata = mem_rdata;
`endif
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with READ_LAT=1, one with READ_LAT=3.
module tb_mem_responder;

    logic            clock = 1'b0;
    logic [1:0]      reset;
    logic [1:0]      req_valid, req_ready, req_we, rsp_valid, rsp_ready, busy;
    logic [1:0][3:0] req_addr;
    logic [1:0][7:0] req_wdata, rsp_rdata;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];

    typedef struct {
        int         dut;
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
        int         hold;
    } vec_t;
    vec_t vecs[8];

    always #5 clock = ~clock;

    mem_responder #(.DATA_W(8), .ADDR_W(4), .READ_LAT(1)) u_dut1 (
        .clock(clock), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0])
    );

    mem_responder #(.DATA_W(8), .ADDR_W(4), .READ_LAT(3)) u_dut3 (
        .clock(clock), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input int s);
        int n = 0;
        while (!req_ready[s] && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) chk("req_ready_timeout", 32'(req_ready[s]), 32'd1);
    endtask

    task automatic do_write(input int s, input logic [3:0] a, input logic [7:0] d);
        @(negedge clock);
        req_valid[s] = 1'b1; req_we[s] = 1'b1; req_addr[s] = a; req_wdata[s] = d;
        wait_ready(s);
        @(posedge clock);
        @(negedge clock);
        req_valid[s] = 1'b0; req_we[s] = 1'b0; req_wdata[s] = ~d;
`ifdef MEM_RESPONDER_WRITE_ACK_EN
        chk("wack_valid", 32'(rsp_valid[s]), 32'd1);
        chk("wack_data", 32'(rsp_rdata[s]), 32'(d));
        chk("wack_req_ready", 32'(req_ready[s]), 32'd0);
        rsp_ready[s] = 1'b1;
        @(negedge clock);
        rsp_ready[s] = 1'b0;
        chk("wack_done_valid", 32'(rsp_valid[s]), 32'd0);
`else
        chk("write_no_rsp", 32'(rsp_valid[s]), 32'd0);
        chk("write_busy", 32'(busy[s]), 32'd0);
`endif
        chk("write_req_ready", 32'(req_ready[s]), 32'd1);
    endtask

    task automatic do_read(input int s, input logic [3:0] a, input logic [7:0] exp, input int hold);
        int k;
        int lat;
        logic [7:0] held;
        logic [7:0] got;
        lat = (s == 0) ? 1 : 3;
        @(negedge clock);
        req_valid[s] = 1'b1; req_we[s] = 1'b0; req_addr[s] = a; req_wdata[s] = 8'hEE; rsp_ready[s] = 1'b0;
        wait_ready(s);
        sb.push_back(exp);
        @(posedge clock);
        @(negedge clock);
        // Changing these while not ready must not disturb the transaction.
        req_valid[s] = 1'b0; req_addr[s] = ~a; req_we[s] = 1'b1;
        k = 1;
        while (!rsp_valid[s] && k < 20) begin
            @(negedge clock);
            k++;
        end
        req_we[s] = 1'b0;
        chk("read_latency", 32'(k), 32'(lat));
        held = rsp_rdata[s];
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("hold_valid", 32'(rsp_valid[s]), 32'd1);
            chk("hold_data", 32'(rsp_rdata[s]), 32'(held));
            chk("hold_req_ready", 32'(req_ready[s]), 32'd0);
            chk("hold_busy", 32'(busy[s]), 32'd1);
        end
        rsp_ready[s] = 1'b1;
        got = rsp_rdata[s];
        if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
        else chk("read_data", 32'(got), 32'(sb.pop_front()));
        @(negedge clock);
        rsp_ready[s] = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid[s]), 32'd0);
        chk("post_rsp_req_ready", 32'(req_ready[s]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        vecs[0] = '{0, 1'b0, 4'h3, 8'h00, 0};
        vecs[1] = '{0, 1'b1, 4'hF, 8'hA5, 0};
        vecs[2] = '{0, 1'b0, 4'hF, 8'hA5, 0};
        vecs[3] = '{1, 1'b1, 4'h2, 8'h3C, 0};
        vecs[4] = '{1, 1'b0, 4'h2, 8'h3C, 4};
        vecs[5] = '{0, 1'b1, 4'h7, 8'hC3, 0};
        vecs[6] = '{0, 1'b0, 4'h7, 8'hC3, 2};
        vecs[7] = '{1, 1'b0, 4'hF, 8'h00, 0};

        reset = 2'b11; req_valid = '0; req_we = '0; rsp_ready = '0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clock);
        reset = 2'b00;
        for (int s = 0; s < 2; s++) begin
            chk("rst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
            chk("rst_rdata", 32'(rsp_rdata[s]), 32'd0);
            chk("rst_busy", 32'(busy[s]), 32'd0);
            chk("rst_req_ready", 32'(req_ready[s]), 32'd1);
        end

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].we) do_write(vecs[i].dut, vecs[i].addr, vecs[i].data);
            else do_read(vecs[i].dut, vecs[i].addr, vecs[i].data, vecs[i].hold);
        end

        // Reset while the slow instance is waiting on a read.
        do_write(1, 4'h1, 8'h77);
        @(negedge clock);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 4'h1;
        @(posedge clock);
        @(negedge clock);
        req_valid[1] = 1'b0;
        chk("wait_busy", 32'(busy[1]), 32'd1);
        reset[1] = 1'b1;
        @(negedge clock);
        reset[1] = 1'b0;
        chk("midrst_busy", 32'(busy[1]), 32'd0);
        chk("midrst_req_ready", 32'(req_ready[1]), 32'd1);
        chk("midrst_rdata", 32'(rsp_rdata[1]), 32'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (rsp_valid[1]) bad++;
        end
        chk("midrst_no_rsp", 32'(bad), 32'd0);
        do_read(1, 4'h1, 8'h00, 0);

        // Back-to-back writes across the whole address range, then read each back.
`ifdef MEM_RESPONDER_WRITE_ACK_EN
        for (int i = 0; i < 16; i++) do_write(0, 4'(i), 8'(i + 1));
`else
        @(negedge clock);
        for (int i = 0; i < 16; i++) begin
            req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 4'(i); req_wdata[0] = 8'(i + 1);
            chk("b2b_req_ready", 32'(req_ready[0]), 32'd1);
            @(negedge clock);
        end
        req_valid[0] = 1'b0; req_we[0] = 1'b0;
        chk("b2b_no_rsp", 32'(rsp_valid[0]), 32'd0);
`endif
        for (int i = 0; i < 16; i++) do_read(0, 4'(i), 8'(i + 1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
